// File: rtl/cnn_loop_counter.sv
// -----------------------------------------------------------------------------
// cnn_loop_counter
// Nested loop counter for CNN address generation. DIMS_P cascaded levels,
// level 0 innermost. Each level has a trip count (limit) and a stride that
// are latched on an accepted start. Every enabled step advances level 0.
// A level advances only when all inner levels are on their final iteration.
//
// Ports
//   clk_i     rising-edge clock
//   reset_i   asynchronous active-high reset
//   start_i   latch limit_i/stride_i and begin iterating (IDLE only)
//   limit_i   per-level trip count, level k at [k*WIDTH_P +: WIDTH_P]
//   stride_i  per-level index increment, same packing
//   en_i      advance one step (RUN only)
//   busy_o    high while iterating
//   idx_o     per-level index = iteration * stride mod 2^WIDTH_P
//   last_o    level k is on its final iteration (RUN only)
//   wrap_o    pulse: level k wrapped on the previous step
//   done_o    pulse: the previous step was the final one
//   err_o     pulse: start rejected because some limit was zero
// -----------------------------------------------------------------------------
module cnn_loop_counter #(
    parameter int DIMS_P  = 3,
    parameter int WIDTH_P = 8
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       start_i,
    input  logic [DIMS_P*WIDTH_P-1:0]  limit_i,
    input  logic [DIMS_P*WIDTH_P-1:0]  stride_i,
    input  logic                       en_i,
    output logic                       busy_o,
    output logic [DIMS_P*WIDTH_P-1:0]  idx_o,
    output logic [DIMS_P-1:0]          last_o,
    output logic [DIMS_P-1:0]          wrap_o,
    output logic                       done_o,
    output logic                       err_o
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                      state_r;
    logic [DIMS_P*WIDTH_P-1:0]   limit_r;
    logic [DIMS_P*WIDTH_P-1:0]   stride_r;
    logic [DIMS_P*WIDTH_P-1:0]   cnt_r;
    logic [DIMS_P*WIDTH_P-1:0]   idx_r;
    logic [DIMS_P-1:0]           wrap_r;
    logic                        done_r;
    logic                        err_r;

    logic                        run_s;
    logic [DIMS_P-1:0]           last_s;
    logic [DIMS_P-1:0]           adv_s;
    logic                        carry_s;
    logic                        final_s;

    // True when any level's trip count field is zero (such a config cannot run).
    function automatic logic any_limit_zero(input logic [DIMS_P*WIDTH_P-1:0] lim);
        logic z;
        z = 1'b0;
        for (int k = 0; k < DIMS_P; k++) begin
            z = z | (lim[k*WIDTH_P +: WIDTH_P] == {WIDTH_P{1'b0}});
        end
        return z;
    endfunction

    // Last flags and the carry chain: a level advances when every inner level is last.
    always_comb begin
        run_s   = (state_r == ST_RUN);
        last_s  = '0;
        adv_s   = '0;
        carry_s = en_i & run_s;
        for (int k = 0; k < DIMS_P; k++) begin
            last_s[k] = run_s &
                        (cnt_r[k*WIDTH_P +: WIDTH_P] ==
                         (limit_r[k*WIDTH_P +: WIDTH_P] - WIDTH_P'(1)));
            adv_s[k]  = carry_s;
            carry_s   = carry_s & last_s[k];
        end
        // Carry out of the outermost level marks the final step of the nest.
        final_s = carry_s;
    end

    // Control FSM, per-level counters/indices and the pulse outputs.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r  <= ST_IDLE;
            limit_r  <= '0;
            stride_r <= '0;
            cnt_r    <= '0;
            idx_r    <= '0;
            wrap_r   <= '0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            wrap_r <= '0;
            done_r <= 1'b0;
            err_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start_i) begin
                        if (any_limit_zero(limit_i)) begin
                            err_r <= 1'b1;
                        end else begin
                            limit_r  <= limit_i;
                            stride_r <= stride_i;
                            cnt_r    <= '0;
                            idx_r    <= '0;
                            state_r  <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    for (int k = 0; k < DIMS_P; k++) begin
                        if (adv_s[k]) begin
                            if (last_s[k]) begin
                                cnt_r[k*WIDTH_P +: WIDTH_P] <= '0;
                                idx_r[k*WIDTH_P +: WIDTH_P] <= '0;
                                wrap_r[k]                   <= 1'b1;
                            end else begin
                                cnt_r[k*WIDTH_P +: WIDTH_P] <= cnt_r[k*WIDTH_P +: WIDTH_P] + WIDTH_P'(1);
                                idx_r[k*WIDTH_P +: WIDTH_P] <= idx_r[k*WIDTH_P +: WIDTH_P] +
                                                               stride_r[k*WIDTH_P +: WIDTH_P];
                            end
                        end
                    end
                    if (final_s) begin
                        done_r  <= 1'b1;
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy_o = run_s;
    assign idx_o  = idx_r;
    assign last_o = last_s;
    assign wrap_o = wrap_r;
    assign done_o = done_r;
    assign err_o  = err_r;

endmodule

// File: tb/tb_cnn_loop_counter.sv
module tb_cnn_loop_counter;
    localparam int D = 2;
    localparam int W = 4;

    logic           clk = 1'b0;
    logic           reset_i;
    logic           start_i;
    logic           en_i;
    logic [D*W-1:0] limit_i;
    logic [D*W-1:0] stride_i;
    logic           busy_o;
    logic [D*W-1:0] idx_o;
    logic [D-1:0]   last_o;
    logic [D-1:0]   wrap_o;
    logic           done_o;
    logic           err_o;

    int errors = 0;
    int checks = 0;

    cnn_loop_counter #(.DIMS_P(D), .WIDTH_P(W)) dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .start_i (start_i),
        .limit_i (limit_i),
        .stride_i(stride_i),
        .en_i    (en_i),
        .busy_o  (busy_o),
        .idx_o   (idx_o),
        .last_o  (last_o),
        .wrap_o  (wrap_o),
        .done_o  (done_o),
        .err_o   (err_o)
    );

    always #5 clk = ~clk;

    // Reference model: a run is a flat step count n over the product of limits.
    int       m_lim [D];
    int       m_str [D];
    bit       m_run;
    int       m_n;
    bit [D-1:0] m_wrap;
    bit       m_done;
    bit       m_err;

    function automatic int below(input int k);
        int p;
        p = 1;
        for (int j = 0; j < k; j++) p = p * m_lim[j];
        return p;
    endfunction

    function automatic int iter_of(input int k);
        if (!m_run) return 0;
        return (m_n / below(k)) % m_lim[k];
    endfunction

    function automatic logic [D*W-1:0] exp_idx();
        logic [D*W-1:0] v;
        v = '0;
        for (int k = 0; k < D; k++) v[k*W +: W] = W'((iter_of(k) * m_str[k]) % 16);
        return v;
    endfunction

    function automatic logic [D-1:0] exp_last();
        logic [D-1:0] v;
        v = '0;
        for (int k = 0; k < D; k++) v[k] = m_run && (iter_of(k) == m_lim[k] - 1);
        return v;
    endfunction

    always @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            m_run = 1'b0; m_n = 0; m_wrap = '0; m_done = 1'b0; m_err = 1'b0;
            for (int k = 0; k < D; k++) begin m_lim[k] = 0; m_str[k] = 0; end
        end else begin
            m_wrap = '0; m_done = 1'b0; m_err = 1'b0;
            if (!m_run) begin
                if (start_i) begin
                    if (limit_i[3:0] == 4'd0 || limit_i[7:4] == 4'd0) begin
                        m_err = 1'b1;
                    end else begin
                        for (int k = 0; k < D; k++) begin
                            m_lim[k] = int'(limit_i[k*W +: W]);
                            m_str[k] = int'(stride_i[k*W +: W]);
                        end
                        m_n = 0;
                        m_run = 1'b1;
                    end
                end
            end else if (en_i) begin
                m_n = m_n + 1;
                for (int k = 0; k < D; k++)
                    if (m_n % (below(k) * m_lim[k]) == 0) m_wrap[k] = 1'b1;
                if (m_n == below(D)) begin
                    m_done = 1'b1; m_run = 1'b0; m_n = 0;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_model();
        chk("busy", 32'(busy_o), 32'(m_run));
        chk("idx",  32'(idx_o),  32'(exp_idx()));
        chk("last", 32'(last_o), 32'(exp_last()));
        chk("wrap", 32'(wrap_o), 32'(m_wrap));
        chk("done", 32'(done_o), 32'(m_done));
        chk("err",  32'(err_o),  32'(m_err));
    endtask

    // One cycle: compare outputs at the falling edge, then drive the next inputs.
    task automatic cyc(input logic st, input logic en);
        @(negedge clk);
        cmp_model();
        start_i = st;
        en_i    = en;
    endtask

    int e0 [6] = '{1, 2, 0, 1, 2, 0};
    int e1 [6] = '{0, 0, 2, 2, 2, 0};
    int ew [6] = '{0, 0, 1, 0, 0, 3};
    int e36[4] = '{0, 6, 12, 2};

    initial begin
        reset_i = 1'b1; start_i = 1'b0; en_i = 1'b0;
        limit_i = 8'h00; stride_i = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_idx",  32'(idx_o),  32'd0);
        chk("rst_out",  32'({last_o, wrap_o, done_o, err_o}), 32'd0);
        reset_i = 1'b0;

        // L0=3 L1=2, strides 1,2, continuous enable; then back-to-back start.
        limit_i = 8'h23; stride_i = 8'h21;
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b1);
        chk("t1_busy", 32'(busy_o), 32'd1);
        chk("t1_idx0", 32'(idx_o), 32'h00);
        for (int s = 1; s <= 6; s++) begin
            if (s == 6) begin limit_i = 8'h14; stride_i = 8'h06; end
            cyc(s == 6 ? 1'b1 : 1'b0, s < 6 ? 1'b1 : 1'b0);
            chk("t1_i0",   32'(idx_o[3:0]), 32'(e0[s-1]));
            chk("t1_i1",   32'(idx_o[7:4]), 32'(e1[s-1]));
            chk("t1_wrap", 32'(wrap_o),     32'(ew[s-1]));
            chk("t1_done", 32'(done_o),     32'(s == 6 ? 1 : 0));
        end
        chk("t1_end_busy", 32'(busy_o), 32'd0);

        // Back-to-back start: L0=4 stride 6 (mod 16), L1=1.
        for (int s = 0; s < 4; s++) begin
            cyc(1'b0, 1'b1);
            chk("t3_busy", 32'(busy_o), 32'd1);
            chk("t3_idx0", 32'(idx_o[3:0]), 32'(e36[s]));
            chk("t3_last", 32'(last_o), s == 3 ? 32'd3 : 32'd2);
        end
        cyc(1'b0, 1'b0);
        chk("t3_done", 32'(done_o), 32'd1);
        chk("t3_wrap", 32'(wrap_o), 32'd3);
        chk("t3_idx",  32'(idx_o),  32'd0);

        // Enable pattern 1,0,0,1 holds the index; start during RUN ignored.
        limit_i = 8'h23; stride_i = 8'h21;
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0); chk("t2_a", 32'(idx_o[3:0]), 32'd1);
        cyc(1'b0, 1'b0); chk("t2_b", 32'(idx_o[3:0]), 32'd1);
        chk("t2_nowrap", 32'({wrap_o, done_o}), 32'd0);
        limit_i = 8'hFF;
        cyc(1'b1, 1'b1); chk("t2_c", 32'(idx_o[3:0]), 32'd1);
        cyc(1'b0, 1'b0); chk("t2_d", 32'(idx_o[3:0]), 32'd2);
        for (int i = 0; i < 20 && busy_o; i++) cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0);
        chk("t2_idle", 32'(busy_o), 32'd0);

        // Zero limit rejected.
        limit_i = 8'h30;
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b1);
        chk("t4_err",  32'(err_o),  32'd1);
        chk("t4_busy", 32'(busy_o), 32'd0);
        cyc(1'b0, 1'b1);
        chk("t4_err2", 32'(err_o),  32'd0);
        chk("t4_idx",  32'(idx_o),  32'd0);

        // L0=1 L1=3 stride 1.
        limit_i = 8'h31; stride_i = 8'h11;
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b1); chk("t5_last0", 32'(last_o), 32'd1);
        cyc(1'b0, 1'b1); chk("t5_i1a", 32'(idx_o[7:4]), 32'd1); chk("t5_w", 32'(wrap_o), 32'd1);
        cyc(1'b0, 1'b1); chk("t5_i1b", 32'(idx_o[7:4]), 32'd2); chk("t5_last", 32'(last_o), 32'd3);
        cyc(1'b0, 1'b0); chk("t5_done", 32'(done_o), 32'd1); chk("t5_busy", 32'(busy_o), 32'd0);

        // Async reset mid-run at idx0=1.
        limit_i = 8'h23; stride_i = 8'h21;
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0); chk("t6_pre", 32'(idx_o[3:0]), 32'd1);
        @(posedge clk); #2; reset_i = 1'b1; #1;
        chk("t6_busy", 32'(busy_o), 32'd0);
        chk("t6_idx",  32'(idx_o),  32'd0);
        chk("t6_out",  32'({last_o, wrap_o, done_o, err_o}), 32'd0);
        @(negedge clk); reset_i = 1'b0; en_i = 1'b1;
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b1);
        chk("t6_ign_busy", 32'(busy_o), 32'd0);
        chk("t6_ign_idx",  32'(idx_o),  32'd0);

        // Randomised traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom % 6 == 0) begin
                for (int k = 0; k < D; k++) begin
                    int r;
                    r = $urandom_range(0, 19);
                    limit_i[k*W +: W] = (r == 0) ? 4'd0 : (r == 1) ? 4'd15 : 4'($urandom_range(1, 5));
                    stride_i[k*W +: W] = 4'($urandom_range(0, 15));
                end
            end
            if ($urandom % 600 == 0) begin
                @(posedge clk); #3; reset_i = 1'b1; #1;
                chk("rnd_rst", 32'({busy_o, idx_o, wrap_o, done_o}), 32'd0);
                @(negedge clk); reset_i = 1'b0;
            end
            cyc(($urandom % 8) == 0, ($urandom % 4) != 0);
        end
        cyc(1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
